w450_prefetch: RTL and testbench

- Instruction prefetch queue between the w450 core and the instruction read port of program memory.
- Drives the memory read address itself and runs ahead of the core, buffering up to DEPTH instruction bytes with their addresses.
- The core pops instructions through a valid/ready handshake.
- On a taken branch or jump, the core issues a redirect that flushes the queue and restarts fetch at a new address.

---
 rtl/w450_prefetch.sv | 145 ++++++++++++++
 tb/tb_w450_prefetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/w450_prefetch.sv
// ---------------------------------------------------------------------------
// w450_prefetch
//
// Instruction prefetch queue for the w450 core. The block drives the program
// memory read address directly and runs ahead of the core. It buffers up to
// DEPTH instruction bytes together with the address each one was fetched
// from. The core consumes entries through a valid/ready handshake. A
// redirect (taken branch or jump) flushes the queue and restarts fetch at a
// new address.
//
// Parameters
//   n      data and address width in bits
//   DEPTH  number of queue entries (power of two, at least 2)
//   AW     log2(DEPTH), the pointer width
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   mem_rd_addr  program memory read address (the fetch_pc register)
//   mem_rd_data  program memory read data, combinational from mem_rd_addr
//   fetch_en     1 = new pushes allowed; pops and redirect work regardless
//   redirect     1 = flush the queue and load fetch_pc from redirect_pc
//   redirect_pc  new fetch address, sampled while redirect=1
//   instr_valid  head entry present
//   instr_ready  core accepts the head entry this cycle
//   instr_data   head entry instruction byte
//   instr_pc     address the head entry was fetched from
//   count        current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module w450_prefetch #(
    parameter int n     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    output logic [n-1:0]  mem_rd_addr,
    input  logic [n-1:0]  mem_rd_data,
    input  logic          fetch_en,
    input  logic          redirect,
    input  logic [n-1:0]  redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [n-1:0]  instr_data,
    output logic [n-1:0]  instr_pc,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Queue state
    logic [n-1:0]  fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW:0]   count_q,    count_d;

    // Entry storage; each entry needs an async clear, so these are flops
    logic [n-1:0]  data_q [DEPTH];
    logic [n-1:0]  data_d [DEPTH];
    logic [n-1:0]  pc_q   [DEPTH];
    logic [n-1:0]  pc_d   [DEPTH];

    logic          pop;
    logic          push;

    // Redirect suppresses both handshakes so the flush sees a clean queue.
    // A push into a full queue is allowed only when the head leaves in the
    // same cycle, which is what keeps streaming at one entry per cycle.
    always_comb begin
        pop  = (count_q != '0) & instr_ready & ~redirect;
        push = fetch_en & ~redirect & ((count_q < DEPTH_C) | pop);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + n'(1);   // silent wrap at 2^n-1
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // One write-enabled register pair per entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                data_d[gi] = data_q[gi];
                pc_d[gi]   = pc_q[gi];
                if (push && (wr_ptr_q == AW'(gi))) begin
                    data_d[gi] = mem_rd_data;
                    pc_d[gi]   = fetch_pc_q;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_q[gi] <= '0;
                    pc_q[gi]   <= '0;
                end else begin
                    data_q[gi] <= data_d[gi];
                    pc_q[gi]   <= pc_d[gi];
                end
            end
        end
    endgenerate

    assign mem_rd_addr = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];
    assign count       = count_q;

endmodule

// File: tb/tb_w450_prefetch.sv
// ---------------------------------------------------------------------------
// tb_w450_prefetch
//
// Bench for w450_prefetch: a table of directed vectors with hand-derived
// expected outputs, hand-written gate and async-reset sequences, then a
// randomized run checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_w450_prefetch;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  mem_rd_addr;
    logic [N-1:0]  mem_rd_data;
    logic          fetch_en;
    logic          redirect;
    logic [N-1:0]  redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [N-1:0]  instr_data;
    logic [N-1:0]  instr_pc;
    logic [AW:0]   count;

    logic [N-1:0]  mem [256];

    assign mem_rd_data = mem[mem_rd_addr];

    always #5 clk = ~clk;

    w450_prefetch #(.n(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .count       (count)
    );

    // ---------------------------------------------------------------
    // Counters
    // ---------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: an ordered list of (data, pc) plus the fetch address
    // ---------------------------------------------------------------
    typedef struct packed {
        logic [N-1:0] data;
        logic [N-1:0] pc;
    } ent_t;

    ent_t         mq[$];
    logic [N-1:0] m_fpc;

    task automatic model_reset();
        mq.delete();
        m_fpc = '0;
    endtask

    task automatic model_edge();
        bit do_pop, do_push;
        ent_t e;
        if (redirect) begin
            mq.delete();
            m_fpc = redirect_pc;
        end else begin
            do_pop  = (mq.size() > 0) && instr_ready;
            do_push = fetch_en && ((mq.size() < DEPTH) || do_pop);
            e.data  = mem[m_fpc];
            e.pc    = m_fpc;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(e);
                m_fpc = m_fpc + 8'd1;
            end
        end
    endtask

    // ---------------------------------------------------------------
    // Cycle helpers
    // ---------------------------------------------------------------
    task automatic drive(input logic fe, input logic rd, input logic [N-1:0] rpc,
                         input logic rdy);
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        #1;
    endtask

    // ---------------------------------------------------------------
    // Directed vectors
    // ---------------------------------------------------------------
    typedef struct {
        string        tag;
        logic         fe;
        logic         rd;
        logic [N-1:0] rpc;
        logic         rdy;
        int           cnt;
        logic         vld;
        logic [N-1:0] dat;
        logic [N-1:0] pc;
        logic [N-1:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string tag, input logic fe, input logic rd,
                                input logic [N-1:0] rpc, input logic rdy,
                                input int cnt, input logic vld,
                                input logic [N-1:0] dat, input logic [N-1:0] pc,
                                input logic [N-1:0] addr);
        vec_t v;
        v.tag = tag; v.fe = fe; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.dat = dat; v.pc = pc; v.addr = addr;
        tbl.push_back(v);
    endfunction

    // Checks outputs before the edge, then clocks the vector in
    task automatic run_vec(input vec_t v);
        drive(v.fe, v.rd, v.rpc, v.rdy);
        #1;
        $display("vec %-8s fe=%0b rd=%0b rdy=%0b cnt=%0d vld=%0b pc=%02h dat=%02h addr=%02h",
                 v.tag, v.fe, v.rd, v.rdy, count, instr_valid, instr_pc, instr_data, mem_rd_addr);
        chk({v.tag, ".count"},       int'(count),       v.cnt);
        chk({v.tag, ".instr_valid"}, int'(instr_valid), int'(v.vld));
        chk({v.tag, ".mem_rd_addr"}, int'(mem_rd_addr), int'(v.addr));
        if (v.vld) begin
            chk({v.tag, ".instr_data"}, int'(instr_data), int'(v.dat));
            chk({v.tag, ".instr_pc"},   int'(instr_pc),   int'(v.pc));
        end
        finish_cycle();
    endtask

    task automatic hv(input string tag, input logic fe, input logic rd,
                      input logic [N-1:0] rpc, input logic rdy, input int cnt,
                      input logic vld, input logic [N-1:0] dat,
                      input logic [N-1:0] pc, input logic [N-1:0] addr);
        vec_t v;
        v.tag = tag; v.fe = fe; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.dat = dat; v.pc = pc; v.addr = addr;
        run_vec(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".count"},       int'(count),       0);
        chk({tag, ".instr_valid"}, int'(instr_valid), 0);
        chk({tag, ".mem_rd_addr"}, int'(mem_rd_addr), 0);
        chk({tag, ".instr_data"},  int'(instr_data),  0);
        chk({tag, ".instr_pc"},    int'(instr_pc),    0);
    endtask

    // ---------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        model_reset();

        //   tag     fe rd rpc    rdy cnt vld dat    pc     addr
        // Fill
        add("fill0",  1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        add("fill1",  1, 0, 8'h00, 0, 1, 1, 8'h10, 8'h00, 8'h01);
        add("fill2",  1, 0, 8'h00, 0, 2, 1, 8'h10, 8'h00, 8'h02);
        add("fill3",  1, 0, 8'h00, 0, 3, 1, 8'h10, 8'h00, 8'h03);
        add("fill4",  1, 0, 8'h00, 0, 4, 1, 8'h10, 8'h00, 8'h04);
        add("full",   1, 0, 8'h00, 0, 4, 1, 8'h10, 8'h00, 8'h04);
        // Stream while full
        add("strm0",  1, 0, 8'h00, 1, 4, 1, 8'h10, 8'h00, 8'h04);
        add("strm1",  1, 0, 8'h00, 1, 4, 1, 8'h11, 8'h01, 8'h05);
        add("strm2",  1, 0, 8'h00, 1, 4, 1, 8'h12, 8'h02, 8'h06);
        add("strm3",  1, 0, 8'h00, 1, 4, 1, 8'h13, 8'h03, 8'h07);
        add("strm4",  1, 0, 8'h00, 1, 4, 1, 8'h14, 8'h04, 8'h08);
        add("strm5",  1, 0, 8'h00, 1, 4, 1, 8'h15, 8'h05, 8'h09);
        // Redirect to 0x40 while full and ready
        add("redir",  1, 1, 8'h40, 1, 4, 1, 8'h16, 8'h06, 8'h0A);
        add("redir1", 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h40);
        add("redir2", 1, 0, 8'h00, 0, 1, 1, 8'h50, 8'h40, 8'h41);
        add("redir3", 1, 0, 8'h00, 1, 2, 1, 8'h50, 8'h40, 8'h42);
        // Redirect to 0xFE and wrap through 0x00
        add("wrapr",  1, 1, 8'hFE, 1, 2, 1, 8'h51, 8'h41, 8'h43);
        add("wrap0",  1, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'hFE);
        add("wrap1",  1, 0, 8'h00, 1, 1, 1, 8'h0E, 8'hFE, 8'hFF);
        add("wrap2",  1, 0, 8'h00, 1, 1, 1, 8'h0F, 8'hFF, 8'h00);
        add("wrap3",  1, 0, 8'h00, 1, 1, 1, 8'h10, 8'h00, 8'h01);
        add("wrap4",  1, 0, 8'h00, 1, 1, 1, 8'h11, 8'h01, 8'h02);

        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Gate: fill two entries at 0x80, then drain with fetch_en=0
        hv("gater",  1, 1, 8'h80, 0, 1, 1, 8'h12, 8'h02, 8'h03);
        hv("gate0",  1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h80);
        hv("gate1",  1, 0, 8'h00, 0, 1, 1, 8'h90, 8'h80, 8'h81);
        hv("gate2",  0, 0, 8'h00, 1, 2, 1, 8'h90, 8'h80, 8'h82);
        hv("gate3",  0, 0, 8'h00, 1, 1, 1, 8'h91, 8'h81, 8'h82);
        hv("gate4",  0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h82);
        hv("gate5",  0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h82);

        // Async reset with three entries queued
        hv("arstr",  0, 1, 8'h20, 1, 0, 0, 8'h00, 8'h00, 8'h82);
        hv("arst0",  1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h20);
        hv("arst1",  1, 0, 8'h00, 0, 1, 1, 8'h30, 8'h20, 8'h21);
        hv("arst2",  1, 0, 8'h00, 0, 2, 1, 8'h30, 8'h20, 8'h22);
        #1;
        chk("arst.pre_count", int'(count), 3);
        #1;
        reset = 1'b0;            // mid-cycle, well before the next edge
        #1;
        $display("async reset asserted mid-cycle: cnt=%0d vld=%0b addr=%02h", count, instr_valid, mem_rd_addr);
        check_reset_outputs("arst.async");
        finish_cycle();
        #2;
        reset = 1'b1;
        hv("arst3",  1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        hv("arst4",  1, 0, 8'h00, 0, 1, 1, 8'h10, 8'h00, 8'h01);

        // Randomized run against the reference model
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            ent_t head;
            drive(($urandom_range(3) != 0), ($urandom_range(15) == 0),
                  8'($urandom), 1'($urandom));
            #1;
            $display("rnd %0d fe=%0b rd=%0b rdy=%0b cnt=%0d pc=%02h addr=%02h",
                     c, fetch_en, redirect, instr_ready, count, instr_pc, mem_rd_addr);
            chk("rnd.count",       int'(count),       mq.size());
            chk("rnd.instr_valid", int'(instr_valid), int'(mq.size() != 0));
            chk("rnd.mem_rd_addr", int'(mem_rd_addr), int'(m_fpc));
            if (mq.size() != 0) begin
                head = mq[0];
                chk("rnd.instr_data", int'(instr_data), int'(head.data));
                chk("rnd.instr_pc",   int'(instr_pc),   int'(head.pc));
            end
            finish_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
